// File: rtl/core_ex_lsu_bus.sv
// Execute-stage load/store unit: accepts one access from the core, runs a single
// valid/ready request and valid-response transaction on the data bus, returns an extended result.
module core_ex_lsu_bus #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_load,
    input  logic              i_store,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic              o_valid,
    input  logic              i_out_ready,
    output logic [XLEN-1:0]   o_rdata,
    output logic              o_misalign,
    output logic              o_bus_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic              mem_req_wen,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    input  logic              mem_rsp_err
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              load_q, load_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [OW-1:0]     off_q, off_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              misalign_q, misalign_d;
    logic              bus_err_q, bus_err_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic              req_wen_q, req_wen_d;
    logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
    logic [NB-1:0]     req_wmask_q, req_wmask_d;

    logic              acc_mis;
    logic [2:0]        align_mask;
    logic [NB-1:0]     lane_mask;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   keep;
    logic              sign_bit;
    logic [XLEN-1:0]   ext;
    logic              timeout;

    // Alignment check and store lane placement, evaluated on the incoming access.
    always_comb begin
        align_mask = (3'b001 << i_size) - 3'd1;
        acc_mis    = (|(i_addr[2:0] & align_mask)) || ((XLEN == 32) && (i_size == 2'd3));
        case (i_size)
            2'd0:    lane_mask = NB'(1);
            2'd1:    lane_mask = NB'(3);
            2'd2:    lane_mask = NB'(15);
            default: lane_mask = '1;
        endcase
    end

    // Load lane extraction: shift the selected lane down, then sign- or zero-extend.
    always_comb begin
        shifted = mem_rsp_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0: begin keep = XLEN'(8'hFF);         sign_bit = shifted[7];      end
            2'd1: begin keep = XLEN'(16'hFFFF);      sign_bit = shifted[15];     end
            2'd2: begin keep = XLEN'(32'hFFFF_FFFF); sign_bit = shifted[31];     end
            default: begin keep = '1;                sign_bit = shifted[XLEN-1]; end
        endcase
        ext = (shifted & keep) | ((sign_bit && !unsigned_q) ? ~keep : '0);
    end

    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        load_d      = load_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        misalign_d  = misalign_q;
        bus_err_d   = bus_err_q;
        req_addr_d  = req_addr_q;
        req_wen_d   = req_wen_q;
        req_wdata_d = req_wdata_q;
        req_wmask_d = req_wmask_q;
        case (state_q)
            S_IDLE: begin
                if (i_valid && (i_load || i_store)) begin
                    load_d      = i_load;
                    size_d      = i_size;
                    unsigned_d  = i_unsigned;
                    off_d       = i_addr[OW-1:0];
                    cnt_d       = '0;
                    rdata_d     = '0;
                    bus_err_d   = 1'b0;
                    misalign_d  = acc_mis;
                    req_addr_d  = {i_addr[XLEN-1:OW], {OW{1'b0}}};
                    req_wen_d   = i_store;
                    req_wdata_d = i_wdata << {i_addr[OW-1:0], 3'b000};
                    req_wmask_d = i_store ? (lane_mask << i_addr[OW-1:0]) : '1;
                    state_d     = acc_mis ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                // Timeout wins over a late handshake so the counter never runs past its limit.
                cnt_d = cnt_q + CW'(1);
                if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_DONE;
                end else if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_rsp_valid) begin
                    bus_err_d = mem_rsp_err;
                    rdata_d   = (load_q && !mem_rsp_err) ? ext : '0;
                    state_d   = S_DONE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    rdata_d    = '0;
                    misalign_d = 1'b0;
                    bus_err_d  = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            load_q      <= 1'b0;
            size_q      <= 2'd0;
            unsigned_q  <= 1'b0;
            off_q       <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            req_addr_q  <= '0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            req_wmask_q <= '0;
        end else begin
            state_q     <= state_d;
            load_q      <= load_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            req_addr_q  <= req_addr_d;
            req_wen_q   <= req_wen_d;
            req_wdata_q <= req_wdata_d;
            req_wmask_q <= req_wmask_d;
        end
    end

    assign o_ready       = (state_q == S_IDLE);
    assign o_valid       = (state_q == S_DONE);
    assign mem_req_valid = (state_q == S_REQ);
    assign o_rdata       = rdata_q;
    assign o_misalign    = misalign_q;
    assign o_bus_err     = bus_err_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wen   = req_wen_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wmask = req_wmask_q;

endmodule

// File: doc/core_ex_lsu_bus.md
Name: core_ex_lsu_bus

Overview:
Parametrised execute-stage load/store unit that replaces the fixed single-cycle test LSU.
- Talks to a variable-latency memory port through valid/ready request and valid response channels.
- Supports byte, half, word and, when XLEN=64, double accesses, with sign/zero extension.
- Detects misaligned accesses and reports bus errors and timeouts.
- Sits between the EX issue logic and the data-memory interconnect, with a valid/ready handshake on both the core side and the memory side.

Parameters:
- XLEN, 32, data/address width; legal values are 32 and 64.
- TIMEOUT_CYCLES, 256, maximum cycles from request accept to response; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  core issues an access
- o_ready  output  1  LSU can accept an access
- i_load  input  1  access is a load
- i_store  input  1  access is a store (i_load and i_store are mutually exclusive)
- i_size  input  2  0=byte, 1=half, 2=word, 3=double
- i_unsigned  input  1  zero-extend load data
- i_addr  input  XLEN  byte address
- i_wdata  input  XLEN  store data, LSB-justified
- o_valid  output  1  result available
- i_out_ready  input  1  downstream accepts the result
- o_rdata  output  XLEN  extended load data; 0 for stores and errors
- o_misalign  output  1  access was misaligned or illegal-size
- o_bus_err  output  1  memory error or timeout
- mem_req_valid  output  1  memory request valid
- mem_req_ready  input  1  memory accepts the request
- mem_req_addr  output  XLEN  address aligned down to XLEN/8
- mem_req_wen  output  1  request is a write
- mem_req_wdata  output  XLEN  store data shifted to its byte lane
- mem_req_wmask  output  XLEN/8  byte enables; all ones for reads
- mem_rsp_valid  input  1  response valid, single-cycle pulse
- mem_rsp_rdata  input  XLEN  response data, full aligned word
- mem_rsp_err  input  1  response error

Behaviour:
- Reset value of every output: 0, except o_ready=1. On rst assertion, the FSM returns to IDLE immediately and all latched fields and the counter clear. An abandoned in-flight memory transaction is dropped, and later responses are ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - o_ready=1.
  - i_valid & (i_load | i_store) latches op, size, unsigned, addr and wdata.
  - If misaligned (addr not a multiple of 2^size) or size=3 with XLEN=32: go to DONE with o_misalign=1. No memory request is issued, so o_valid asserts 1 cycle after accept.
  - Otherwise go to REQ.
  - i_valid with neither i_load nor i_store is ignored.
- REQ:
  - mem_req_valid=1; all mem_req_* outputs are registered and held stable until mem_req_ready.
  - The handshake moves the FSM to WAIT.
- WAIT:
  - mem_rsp_valid moves the FSM to DONE. o_bus_err takes mem_rsp_err.
  - For a load without error, o_rdata is latched: the lane selected by addr low bits is extracted, then sign- or zero-extended per size and unsigned.
  - A response arriving in IDLE, REQ or DONE is ignored.
- Timeout:
  - The counter starts at 0 on entry to REQ and increments every cycle in REQ and WAIT.
  - When the counter reaches TIMEOUT_CYCLES-1 with no response, the FSM goes to DONE with o_bus_err=1.
  - If a response and the timeout occur in the same cycle, the response wins.
- DONE:
  - o_valid=1; o_rdata, o_misalign and o_bus_err are held until i_out_ready, then the FSM returns to IDLE.
  - o_ready=0 in REQ, WAIT and DONE. There are no back-to-back accepts, so the minimum accept-to-accept interval for a legal access is 4 cycles.
- Store lane rules:
  - wdata is shifted left by 8*addr[log2(XLEN/8)-1:0].
  - wmask = ((1<<2^size)-1) << low address bits.
- Latency: legal access with immediate ready and a 1-cycle response gives o_valid 3 cycles after accept.

Test Plan:
- XLEN=32, store byte 0xAB at 0x1003 -> mem_req_addr=0x1000, wdata=0xAB000000, wmask=4'b1000, wen=1; o_valid with o_rdata=0.
- Load half signed at 0x2002, memory word 0x80011234 -> o_rdata=0xFFFF8001. Same load unsigned -> 0x00008001. Load byte at 0x2000 signed -> 0x00000034.
- Load word at 0x3002 -> mem_req_valid never asserts; o_valid=1, o_misalign=1 one cycle after accept. Size=3 at XLEN=32 gives the same result.
- mem_req_ready low for 3 cycles, then high; response 2 cycles later with mem_rsp_err=1 -> request fields stable throughout; o_valid with o_bus_err=1 and o_rdata=0. Holding i_out_ready low for 5 cycles keeps the outputs stable.
- TIMEOUT_CYCLES=16, request accepted, no response -> o_bus_err=1 and o_valid 16 cycles after REQ entry. A response arriving in the same cycle as the timeout gives o_bus_err=0 instead.
- rst asserted during WAIT -> o_valid=0, o_ready=1 asynchronously. A stale mem_rsp_valid after rst release produces no o_valid; the next load completes normally.
